mult_share_sched: RTL and testbench



---
 rtl/mult_share_sched.sv | 132 +++++++++++++
 tb/tb_mult_share_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// Round-robin share of one 4-stage pipelined multiplier across NUM_REQ requesters.
// Result appears 4 cycles after acceptance; no result backpressure, one accept per cycle.

// Behavioural stand-in for the DesignWare part: three register stages, no reset.
module DW02_mult_4_stage #(
  parameter int A_width = 16,
  parameter int B_width = 16
) (
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic                       TC,
  input  logic                       CLK,
  output logic [A_width+B_width-1:0] PRODUCT
);
  logic signed [A_width:0]           w_ea;
  logic signed [B_width:0]           w_eb;
  logic signed [A_width+B_width+1:0] w_full;
  logic [A_width+B_width-1:0]        r_p1, r_p2, r_p3;

  assign w_ea   = {TC & A[A_width-1], A};
  assign w_eb   = {TC & B[B_width-1], B};
  assign w_full = w_ea * w_eb;

  always_ff @(posedge CLK) begin
    r_p1 <= w_full[A_width+B_width-1:0];
    r_p2 <= r_p1;
    r_p3 <= r_p2;
  end

  assign PRODUCT = r_p3;
endmodule

module mult_share_sched #(
  parameter int A_width  = 16,
  parameter int B_width  = 16,
  parameter int NUM_REQ  = 4,
  parameter int ID_width = 2
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_width-1:0]   req_a,
  input  logic [NUM_REQ*B_width-1:0]   req_b,
  input  logic [NUM_REQ-1:0]           req_tc,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [ID_width-1:0]          rsp_id,
  output logic [A_width+B_width-1:0]   rsp_product,
  output logic                         busy
);
  typedef struct packed {
    logic                v;
    logic [ID_width-1:0] id;
  } tag_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [ID_width-1:0]        r_ptr;
  tag_t                       r_tag0, r_tag1, r_tag2, r_tag3;
  logic [A_width-1:0]         r_a;
  logic [B_width-1:0]         r_b;
  logic                       r_tc;

  logic                       w_found;
  logic [ID_width-1:0]        w_win;
  int                         w_pos;
  logic [A_width+B_width-1:0] w_prod;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_pos     = 0;
    req_ready = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[w_pos]) begin
        w_found = 1'b1;
        w_win   = ID_width'(w_pos);
      end
    end
    if (!rst_n) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_ptr  <= ID_width'(NUM_REQ - 1);
      r_tag0 <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
    end else begin
      if (w_found) begin
        r_ptr <= w_win;
      end
      r_tag0 <= '{v: w_found, id: w_found ? w_win : '0};
      r_tag1 <= r_tag0;
      r_tag2 <= r_tag1;
      r_tag3 <= r_tag2;
    end
  end

  // Operand registers need no reset; the tag pipeline qualifies them.
  always_ff @(posedge CLK) begin
    if (w_found) begin
      r_a  <= req_a[w_win*A_width +: A_width];
      r_b  <= req_b[w_win*B_width +: B_width];
      r_tc <= req_tc[w_win];
    end
  end

  DW02_mult_4_stage #(
    .A_width (A_width),
    .B_width (B_width)
  ) u_mult (
    .A       (r_a),
    .B       (r_b),
    .TC      (r_tc),
    .CLK     (CLK),
    .PRODUCT (w_prod)
  );

  assign rsp_valid   = r_tag3.v ? (ONE_HOT0 << r_tag3.id) : '0;
  assign rsp_id      = r_tag3.v ? r_tag3.id : '0;
  assign rsp_product = r_tag3.v ? w_prod : '0;
  assign busy        = r_tag0.v | r_tag1.v | r_tag2.v | r_tag3.v;
endmodule

// File: tb/tb_mult_share_sched.sv
// Randomised and directed checks of mult_share_sched against a queue-based model.
module tb_mult_share_sched;
  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_tc, rsp_valid;
  logic [63:0] req_a, req_b;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;
  logic        busy;

  always #5 CLK = ~CLK;

  mult_share_sched #(.A_width(16), .B_width(16), .NUM_REQ(4), .ID_width(2)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tc      (req_tc),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  typedef struct {
    int          due;
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_q[$];
  logic        pend_v[N];
  logic [15:0] pend_a[N], pend_b[N];
  logic        pend_tc[N];
  logic [31:0] last_prod[N];
  logic [3:0]  refill;
  bit          rnd_mode;
  int          ptr, cyc, n_chk, n_fail, rsp_seen, s0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic tc);
    longint sa, sb;
    sa = tc ? longint'($signed(a)) : longint'(a);
    sb = tc ? longint'($signed(b)) : longint'(b);
    return 32'(sa * sb);
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic tc);
    pend_v[i]  = 1'b1;
    pend_a[i]  = a;
    pend_b[i]  = b;
    pend_tc[i] = tc;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend_v[i];
      req_a[i*16 +: 16]  = pend_a[i];
      req_b[i*16 +: 16]  = pend_b[i];
      req_tc[i]          = pend_tc[i];
    end
  endtask

  task automatic step();
    int   win;
    exp_t e;
    drive();
    @(negedge CLK);
    win = -1;
    if (rst_n) begin
      for (int k = 1; k <= N; k++) begin
        if (win < 0 && pend_v[(ptr + k) % N]) win = (ptr + k) % N;
      end
    end
    check_eq("req_ready", req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);
    check_eq("busy", busy, exp_q.size() != 0);
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_eq("rsp_valid", rsp_valid, 64'd1 << e.id);
      check_eq("rsp_id", rsp_id, e.id);
      check_eq("rsp_product", rsp_product, e.prod);
    end else begin
      check_eq("rsp_valid_idle", rsp_valid, 0);
      check_eq("rsp_id_idle", rsp_id, 0);
      check_eq("rsp_product_idle", rsp_product, 0);
    end
    if (rsp_valid != 0) begin
      rsp_seen++;
      last_prod[rsp_id] = rsp_product;
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
    if (win >= 0) begin
      exp_q.push_back('{due: cyc + 4, id: win, prod: ref_mul(pend_a[win], pend_b[win], pend_tc[win])});
      ptr = win;
    end
    @(posedge CLK);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      ptr = N - 1;
    end else if (win >= 0) begin
      pend_v[win] = 1'b0;
      if (refill[win]) set_req(win, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    if (rnd_mode) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 1) == 1)
          set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; rsp_seen = 0; cyc = 0;
    ptr = N - 1; refill = '0; rnd_mode = 0;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0; pend_a[i] = '0; pend_b[i] = '0; pend_tc[i] = 0; last_prod[i] = '0;
    end
    rst_n = 1'b0;
    drive();
    @(posedge CLK);
    #1;
    cyc++;
    step();
    step();
    rst_n = 1'b1;

    // Unsigned basic
    set_req(0, 16'h0003, 16'h0005, 1'b0);
    step();
    idle(6);
    check_eq("basic_unsigned", last_prod[0], 32'h0000000F);

    // Signed vs unsigned on the same operands
    set_req(1, 16'hFFFE, 16'h0003, 1'b1);
    step();
    set_req(2, 16'hFFFE, 16'h0003, 1'b0);
    step();
    idle(6);
    check_eq("signed_prod", last_prod[1], 32'hFFFFFFFA);
    check_eq("unsigned_prod", last_prod[2], 32'h0002FFFA);

    // Round-robin fairness from reset priority
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    grant_q.delete();
    refill = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
    idle(8);
    refill = 4'h0;
    idle(10);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_grant%0d", i), grant_q[i], i % N);

    // Pointer rotation: after 2, pattern 0101 alternates 0,2
    grant_q.delete();
    set_req(2, 16'h0007, 16'h0009, 1'b0);
    step();
    refill = 4'b0101;
    set_req(0, 16'h1234, 16'h0002, 1'b0);
    set_req(2, 16'h8000, 16'h0002, 1'b1);
    idle(4);
    refill = 4'h0;
    idle(8);
    check_eq("rot_g0", grant_q[0], 2);
    check_eq("rot_g1", grant_q[1], 0);
    check_eq("rot_g2", grant_q[2], 2);
    check_eq("rot_g3", grant_q[3], 0);
    check_eq("rot_g4", grant_q[4], 2);

    // Reset mid-operation discards in-flight work
    set_req(0, 16'h0011, 16'h0022, 1'b0);
    set_req(1, 16'h0033, 16'h0044, 1'b0);
    set_req(2, 16'h0055, 16'h0066, 1'b0);
    idle(3);
    s0 = rsp_seen;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle(5);
    check_eq("reset_no_rsp", rsp_seen - s0, 0);
    check_eq("reset_busy", busy, 0);
    grant_q.delete();
    set_req(0, 16'h0002, 16'h0002, 1'b0);
    set_req(3, 16'h0003, 16'h0003, 1'b0);
    step();
    check_eq("reset_prio", grant_q[0], 0);
    idle(8);

    // Idle and extreme operands
    idle(3);
    check_eq("idle_ready", req_ready, 0);
    set_req(0, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    set_req(1, 16'hFFFF, 16'hFFFF, 1'b1);
    step();
    idle(6);
    check_eq("max_unsigned", last_prod[0], 32'hFFFE0001);
    check_eq("max_signed", last_prod[1], 32'h00000001);

    // Random traffic with occasional resets
    rnd_mode = 1;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      step();
    end
    rnd_mode = 0;
    rst_n = 1'b1;
    idle(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
